pipe_reg_chain: RTL and testbench
=================================

Name: pipe_reg_chain

Overview:
- Parametrised elastic pipeline register: STAGES cascaded WIDTH-bit registers, each with its own valid bit.
- Valid/ready handshake with bubble collapsing, synchronous flush, and an asynchronous test-preload hook.
- Generic successor to the single write-enable register.
- Used between core pipeline stages (fetch→decode, issue→execute) wherever multi-cycle delay plus backpressure is needed.

Parameters:
- WIDTH, 32, payload bits per stage (≥1)
- STAGES, 2, number of register stages (≥1); zero-backpressure latency in cycles

Ports:
- clk  input  1  clock, rising edge
- rst_aL  input  1  asynchronous active-low reset
- flush  input  1  synchronous flush; invalidates all stages
- in_valid  input  1  upstream has data
- in_ready  output  1  chain accepts data this cycle
- in_data  input  WIDTH  upstream payload
- out_valid  output  1  valid bit of stage STAGES-1
- out_ready  input  1  downstream accepts
- out_data  output  WIDTH  payload of stage STAGES-1
- occupancy  output  $clog2(STAGES+1)  count of valid stages
- init  input  1  test hook: asynchronous preload, highest priority
- init_valid  input  STAGES  preload valid bits; bit i = stage i
- init_data  input  STAGES*WIDTH  preload payloads; stage i at [i*WIDTH +: WIDTH]

Behaviour:
- Reset and clock: rst_aL is asynchronous, active-low; clock is clk.
- Stage state: v[i] and d[i] for i = 0..STAGES-1. Stage 0 is fed by in_*. Stage STAGES-1 drives out_*.
- Ready chain (combinational): rdy[STAGES] = out_ready; rdy[i] = !v[i] | rdy[i+1]; in_ready = rdy[0].
  - Bubbles collapse: an empty stage always accepts, even when out_ready=0.
- Per clock, when not flushing, each stage i with rdy[i]=1:
  - v[i] <= upstream valid (in_valid for i=0, else v[i-1]).
  - d[i] <= upstream data, only when upstream valid=1; otherwise d[i] holds.
- Stages with rdy[i]=0 hold v[i] and d[i].
- Handshake:
  - Transfer in when in_valid & in_ready. Transfer out when out_valid & out_ready.
  - out_data is stable while out_valid=1 and out_ready=0.
- Latency: a beat accepted at edge N appears on out_* after edge N+STAGES-1, i.e. visible in cycle N+STAGES-1 for STAGES=1 semantics. With no backpressure, throughput is 1 beat/cycle.
- occupancy = popcount(v). Combinational from state. Range 0..STAGES.
- Flush (synchronous):
  - All v[i] <= 0 at the next edge; d[i] hold.
  - in_ready still follows the rdy chain, but a beat handshaked in the flush cycle is discarded.
  - out handshake in the flush cycle still counts downstream; the chain drops the beat regardless.
- Priority: init (async) > !rst_aL (async) > flush > normal update.
- Reset: all v=0, all d=0. Outputs: out_valid=0, out_data=0, occupancy=0, in_ready=1. Reset mid-transfer drops all beats.
- Init: while init=1, v=init_valid and d=init_data asynchronously. Normal operation resumes on the first edge after init falls.
- Boundaries:
  - Full chain (all v=1) with out_ready=0: in_ready=0, nothing moves.
  - Full chain with out_ready=1: the whole chain shifts and accepts a new beat in the same cycle.
  - STAGES=1: a single skid-less register, in_ready = !v[0] | out_ready.

Optional Feature:
- Macro: PIPE_REG_CHAIN_STALL_CNT_EN
- Defined:
  - Adds output stall_cnt [15:0].
  - Increments each cycle where out_valid=1 and out_ready=0.
  - Saturates at 16'hFFFF.
  - Cleared by reset and init; not cleared by flush.
- Undefined: port and counter absent. All other behaviour is identical.

Test Plan:
- WIDTH=8, STAGES=3, out_ready=1, in_valid=1 with data 0x11, 0x22, 0x33 on consecutive edges -> out_data 0x11, 0x22, 0x33 on consecutive cycles starting 2 cycles after first acceptance; in_ready stays 1.
- Fill 3 beats (0xA1, 0xA2, 0xA3) with out_ready=0 -> occupancy=3, in_ready=0, out_data=0xA1 held stable. Then out_ready=1 with in_valid=1, data 0xA4 -> 0xA1 retires and 0xA4 is accepted the same cycle; occupancy stays 3.
- Bubble collapse: one beat 0x5C in stage 0, out_ready=0 -> beat advances to stage 2 within 2 cycles; occupancy=1, in_ready=1.
- Flush with 2 valid stages while in_valid=1, data 0xEE -> next cycle occupancy=0, out_valid=0; 0xEE never appears on out_data.
- Assert rst_aL=0 mid-stream between edges -> out_valid=0, out_data=0, occupancy=0 immediately (no clock needed).
- Pulse init with init_valid=3'b101, init_data={0x03, 0x02, 0x01} -> out_valid=1, out_data=0x03, occupancy=2. With macro defined and out_ready=0 for 5 cycles -> stall_cnt=5.

Source files
------------

// File: rtl/pipe_reg_chain.sv
// Elastic pipeline register chain: STAGES valid/ready stages with bubble collapsing, flush and async preload.
// Optional stall counter output enabled by defining PIPE_REG_CHAIN_STALL_CNT_EN.
module pipe_reg_chain #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst_aL,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [$clog2(STAGES+1)-1:0]  occupancy,
  input  logic                         init,
  input  logic [STAGES-1:0]            init_valid,
  input  logic [STAGES*WIDTH-1:0]      init_data
`ifdef PIPE_REG_CHAIN_STALL_CNT_EN
  ,
  output logic [15:0]                  stall_cnt
`endif
);

  localparam int OCC_W = $clog2(STAGES + 1);

  logic [STAGES-1:0]       v_q;
  logic [STAGES-1:0]       v_d;
  logic [STAGES-1:0]       v_s;
  logic [STAGES*WIDTH-1:0] d_q;
  logic [STAGES*WIDTH-1:0] d_d;
  logic [STAGES*WIDTH-1:0] d_s;
  logic [STAGES-1:0]       up_v_s;
  logic [STAGES*WIDTH-1:0] up_d_s;
  logic [STAGES-1:0]       rdy_s;
  logic                    acc_s;
  logic [OCC_W-1:0]        occ_s;

  // While init is high the preload values are visible without waiting for a clock edge.
  assign v_s = init ? init_valid : v_q;
  assign d_s = init ? init_data  : d_q;

  // Stage i is fed by stage i-1; stage 0 by the upstream port.
  assign up_v_s = (v_s << 1) | STAGES'(in_valid);
  assign up_d_s = (d_s << WIDTH) | (STAGES*WIDTH)'(in_data);

  // Ready chain: a stage accepts when empty or when everything downstream of it can move.
  always_comb begin
    acc_s = out_ready;
    rdy_s = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      acc_s    = acc_s | ~v_s[i];
      rdy_s[i] = acc_s;
    end
  end

  // Next-state for every stage; flush only clears valids and leaves payloads untouched.
  always_comb begin
    v_d = v_s;
    d_d = d_s;
    if (flush) begin
      v_d = '0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (rdy_s[i]) begin
          v_d[i] = up_v_s[i];
          if (up_v_s[i]) begin
            d_d[i*WIDTH +: WIDTH] = up_d_s[i*WIDTH +: WIDTH];
          end else begin
            d_d[i*WIDTH +: WIDTH] = d_s[i*WIDTH +: WIDTH];
          end
        end else begin
          v_d[i]                = v_s[i];
          d_d[i*WIDTH +: WIDTH] = d_s[i*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Stage state: async preload wins over async reset, then the clocked update.
  always_ff @(posedge clk or negedge rst_aL or posedge init) begin
    if (init) begin
      v_q <= init_valid;
      d_q <= init_data;
    end else if (!rst_aL) begin
      v_q <= '0;
      d_q <= '0;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  // Population count of valid stages.
  always_comb begin
    occ_s = '0;
    for (int i = 0; i < STAGES; i++) begin
      occ_s = occ_s + OCC_W'(v_s[i]);
    end
  end

  assign in_ready  = rdy_s[0];
  assign out_valid = v_s[STAGES-1];
  assign out_data  = d_s[(STAGES-1)*WIDTH +: WIDTH];
  assign occupancy = occ_s;

`ifdef PIPE_REG_CHAIN_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  // Saturating count of cycles where the head beat is blocked by downstream.
  always_ff @(posedge clk or negedge rst_aL or posedge init) begin
    if (init) begin
      stall_cnt_q <= 16'h0000;
    end else if (!rst_aL) begin
      stall_cnt_q <= 16'h0000;
    end else if (v_s[STAGES-1] && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'h0001;
    end else begin
      stall_cnt_q <= stall_cnt_q;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed bench for pipe_reg_chain (WIDTH=8, STAGES=3) with an output-data scoreboard queue.
module tb_pipe_reg_chain;

  localparam int WIDTH  = 8;
  localparam int STAGES = 3;

  logic                    clk;
  logic                    rst_aL;
  logic                    flush;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        out_data;
  logic [1:0]              occupancy;
  logic                    init;
  logic [STAGES-1:0]       init_valid;
  logic [STAGES*WIDTH-1:0] init_data;
`ifdef PIPE_REG_CHAIN_STALL_CNT_EN
  logic [15:0]             stall_cnt;
`endif

  int tests;
  int fails;
  logic [WIDTH-1:0] sb[$];

  pipe_reg_chain #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk        (clk),
    .rst_aL     (rst_aL),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .occupancy  (occupancy),
    .init       (init),
    .init_valid (init_valid),
    .init_data  (init_data)
`ifdef PIPE_REG_CHAIN_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Score any output handshake about to happen, then advance one clock and settle.
  task automatic tick();
    logic [WIDTH-1:0] exp;
    #1;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_beat", {24'h0, out_data}, 32'hDEAD);
      end else begin
        exp = sb.pop_front();
        chk("out_data_sb", {24'h0, out_data}, {24'h0, exp});
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests      = 0;
    fails      = 0;
    rst_aL     = 1'b0;
    flush      = 1'b0;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    out_ready  = 1'b0;
    init       = 1'b0;
    init_valid = 3'b000;
    init_data  = 24'h000000;

    #12;
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_out_data",  {24'h0, out_data},  32'h0);
    chk("rst_occupancy", {30'h0, occupancy}, 32'h0);
    chk("rst_in_ready",  {31'h0, in_ready},  32'h1);
    rst_aL = 1'b1;
    @(posedge clk);
    #1;

    // Streaming with no backpressure
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h11; sb.push_back(8'h11); tick();
    chk("stream_in_ready0", {31'h0, in_ready}, 32'h1);
    in_data   = 8'h22; sb.push_back(8'h22); tick();
    chk("stream_in_ready1", {31'h0, in_ready}, 32'h1);
    in_data   = 8'h33; sb.push_back(8'h33); tick();
    chk("stream_in_ready2", {31'h0, in_ready}, 32'h1);
    chk("stream_first_valid", {31'h0, out_valid}, 32'h1);
    chk("stream_first_data",  {24'h0, out_data},  32'h11);
    in_valid = 1'b0;
    tick();
    chk("stream_second_data", {24'h0, out_data}, 32'h22);
    tick();
    chk("stream_third_data",  {24'h0, out_data}, 32'h33);
    tick();
    chk("stream_drained_valid", {31'h0, out_valid}, 32'h0);
    chk("stream_drained_occ",   {30'h0, occupancy}, 32'h0);

    // Fill under backpressure, then shift and accept in one cycle
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hA1; sb.push_back(8'hA1); tick();
    in_data   = 8'hA2; sb.push_back(8'hA2); tick();
    in_data   = 8'hA3; sb.push_back(8'hA3); tick();
    chk("full_occ",      {30'h0, occupancy}, 32'h3);
    chk("full_in_ready", {31'h0, in_ready},  32'h0);
    chk("full_out_data", {24'h0, out_data},  32'hA1);
    in_data = 8'hA4;
    tick();
    chk("full_hold_data", {24'h0, out_data},  32'hA1);
    chk("full_hold_occ",  {30'h0, occupancy}, 32'h3);
    out_ready = 1'b1;
    #1;
    chk("full_shift_in_ready", {31'h0, in_ready}, 32'h1);
    sb.push_back(8'hA4);
    tick();
    chk("full_shift_occ",  {30'h0, occupancy}, 32'h3);
    chk("full_shift_data", {24'h0, out_data},  32'hA2);
    in_valid = 1'b0;
    tick();
    tick();
    chk("full_last_data", {24'h0, out_data}, 32'hA4);
    tick();
    chk("full_drained_occ", {30'h0, occupancy}, 32'h0);

    // Bubble collapse under backpressure
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h5C; sb.push_back(8'h5C); tick();
    in_valid  = 1'b0;
    tick();
    tick();
    chk("bubble_out_valid", {31'h0, out_valid}, 32'h1);
    chk("bubble_out_data",  {24'h0, out_data},  32'h5C);
    chk("bubble_occ",       {30'h0, occupancy}, 32'h1);
    chk("bubble_in_ready",  {31'h0, in_ready},  32'h1);
    out_ready = 1'b1;
    tick();
    chk("bubble_drained_occ", {30'h0, occupancy}, 32'h0);

    // Flush with two valid stages while a new beat is offered
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h61; tick();
    in_data   = 8'h62; tick();
    chk("preflush_occ", {30'h0, occupancy}, 32'h2);
    flush   = 1'b1;
    in_data = 8'hEE;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_occ",       {30'h0, occupancy}, 32'h0);
    chk("flush_out_valid", {31'h0, out_valid}, 32'h0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("flush_quiet_valid", {31'h0, out_valid}, 32'h0);

    // Asynchronous reset between edges
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h77; tick();
    in_valid  = 1'b0;
    tick();
    tick();
    chk("prerst_out_valid", {31'h0, out_valid}, 32'h1);
    #2;
    rst_aL = 1'b0;
    #1;
    chk("arst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("arst_out_data",  {24'h0, out_data},  32'h0);
    chk("arst_occ",       {30'h0, occupancy}, 32'h0);
    chk("arst_in_ready",  {31'h0, in_ready},  32'h1);
    #1;
    rst_aL = 1'b1;
    @(posedge clk);
    #1;

    // Asynchronous preload, then stall for five cycles
    init_valid = 3'b101;
    init_data  = {8'h03, 8'h02, 8'h01};
    init       = 1'b1;
    #1;
    chk("init_out_valid", {31'h0, out_valid}, 32'h1);
    chk("init_out_data",  {24'h0, out_data},  32'h03);
    chk("init_occ",       {30'h0, occupancy}, 32'h2);
    #1;
    init = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("stall_out_data", {24'h0, out_data},  32'h03);
    chk("stall_occ",      {30'h0, occupancy}, 32'h2);
`ifdef PIPE_REG_CHAIN_STALL_CNT_EN
    chk("stall_cnt", {16'h0, stall_cnt}, 32'h5);
`endif
    sb.push_back(8'h03);
    sb.push_back(8'h01);
    out_ready = 1'b1;
    tick();
    tick();
    chk("init_drained_occ", {30'h0, occupancy}, 32'h0);
`ifdef PIPE_REG_CHAIN_STALL_CNT_EN
    chk("stall_cnt_hold", {16'h0, stall_cnt}, 32'h5);
`endif

    chk("scoreboard_empty", sb.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
